// File: rtl/alu_op_sequencer.sv
// Operand/result sequencer around the combinational ALU: latch operands, settle,
// capture the 64-bit result, then drain ZLO (and ZHI for MUL/DIV) over valid/ready.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op_in,
    input  logic [31:0] opnd_a,
    input  logic [31:0] opnd_b,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_is_hi,
    output logic        done,
    output logic        err
);

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 5;
    localparam int unsigned CW = 64;
    localparam logic [OW-1:0] OP_MUL = 5'b01111;
    localparam logic [OW-1:0] OP_DIV = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_CAPTURE,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] b_q, b_d;
    logic [OW-1:0] op_q, op_d;
    logic [DW-1:0] zhi_q, zhi_d;
    logic [DW-1:0] zlo_q, zlo_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    function automatic logic is_legal(input logic [OW-1:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
            5'd9, 5'd10, 5'd11,
            5'd15, 5'd16, 5'd17, 5'd18: is_legal = 1'b1;
            default:                    is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            op_q    <= op_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state and register loads; done is a single-cycle pulse into IDLE.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        b_d     = b_q;
        op_d    = op_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d     = opnd_a;
                    b_d     = opnd_b;
                    op_d    = op_in;
                    err_d   = ~is_legal(op_in);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (is_legal(op_q)) begin
                    zhi_d = alu_c[CW-1:DW];
                    zlo_d = alu_c[DW-1:0];
                end else begin
                    zhi_d = '0;
                    zlo_d = '0;
                end
                state_d = S_OUT_LO;
            end
            S_OUT_LO: begin
                if (res_ready) begin
                    if (op_q == OP_MUL || op_q == OP_DIV) begin
                        state_d = S_OUT_HI;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_OUT_HI: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus-side outputs decode registered state only.
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_OUT_LO) || (state_q == S_OUT_HI);
    assign res_is_hi = (state_q == S_OUT_HI);
    assign res_data  = (state_q == S_OUT_LO) ? zlo_q :
                       (state_q == S_OUT_HI) ? zhi_q : '0;
    assign alu_a     = y_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign z_hi      = zhi_q;
    assign z_lo      = zlo_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  op_in = '0;
    logic [31:0] opnd_a = '0;
    logic [31:0] opnd_b = '0;
    logic        busy;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_c;
    logic [31:0] z_hi, z_lo;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_is_hi;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    alu_op_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .op_in(op_in),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .z_hi(z_hi), .z_lo(z_lo), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_is_hi(res_is_hi), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: MUL is a full product, DIV gives {rem, quot}, others {a^b, a+b}.
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 5'd15) return 64'(a) * 64'(b);
        if (op == 5'd16) return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
        return {a ^ b, a + b};
    endfunction

    assign alu_c = alu_fn(alu_op, alu_a, alu_b);

    logic [4:0] legal_ops [12] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11,
                                   5'd15, 5'd16, 5'd17, 5'd18};

    function automatic bit m_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: pending output words plus a settle countdown.
    bit          m_busy;
    int          m_cnt;
    logic [32:0] m_q[$];
    logic [31:0] m_y, m_b, m_zhi, m_zlo;
    logic [4:0]  m_op;
    logic        m_err, m_done;
    logic [63:0] m_r;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_busy = 0; m_cnt = 0; m_q.delete();
            m_y = 0; m_b = 0; m_op = 0; m_zhi = 0; m_zlo = 0; m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_y = opnd_a; m_b = opnd_b; m_op = op_in; m_err = !m_legal(op_in);
                    m_busy = 1; m_cnt = 2;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_r = m_legal(m_op) ? alu_fn(m_op, m_y, m_b) : 64'd0;
                    m_zhi = m_r[63:32];
                    m_zlo = m_r[31:0];
                    m_q.push_back({1'b0, m_zlo});
                    if (m_op == 5'd15 || m_op == 5'd16) m_q.push_back({1'b1, m_zhi});
                end
            end else if (res_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic        ev;
        logic [32:0] front;
        ev = m_busy && (m_cnt == 0) && (m_q.size() > 0);
        front = ev ? m_q[0] : 33'd0;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("res_valid", 64'(res_valid), 64'(ev));
        chk("res_data", 64'(res_data), 64'(front[31:0]));
        chk("res_is_hi", 64'(res_is_hi), 64'(front[32]));
        chk("alu_a", 64'(alu_a), 64'(m_y));
        chk("alu_b", 64'(alu_b), 64'(m_b));
        chk("alu_op", 64'(alu_op), 64'(m_op));
        chk("z_hi", 64'(z_hi), 64'(m_zhi));
        chk("z_lo", 64'(z_lo), 64'(m_zlo));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
    end

    // Words actually handed over, for literal checks.
    logic [32:0] got[$];
    always @(posedge clk) if (res_valid && res_ready) got.push_back({res_is_hi, res_data});

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 60; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 60) chk({nm, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        got.delete();
        @(negedge clk); #1;
        start = 1; op_in = op; opnd_a = a; opnd_b = b;
        @(negedge clk); #1;
        start = 0;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 20; i++) begin
            if (res_valid) break;
            @(negedge clk); #1;
        end
        if (i == 20) chk("valid_timeout", 64'd1, 64'd0);
    endtask

    int lat;

    initial begin
        repeat (3) @(negedge clk);
        #1 clr = 0;

        // ADD: single word 0xC, done three cycles after accept.
        run_op(5'd3, 32'h5, 32'h7, lat);
        chk("add_lat", 64'(lat), 64'd3);
        chk("add_nwords", 64'(got.size()), 64'd1);
        chk("add_word", 64'(got[0]), {31'd0, 1'b0, 32'h0000_000C});

        // MUL: lo then hi word, done four cycles after accept.
        run_op(5'd15, 32'h0001_0000, 32'h0001_0000, lat);
        chk("mul_lat", 64'(lat), 64'd4);
        chk("mul_nwords", 64'(got.size()), 64'd2);
        chk("mul_lo", 64'(got[0]), {31'd0, 1'b0, 32'h0});
        chk("mul_hi", 64'(got[1]), {31'd0, 1'b1, 32'h1});

        // Illegal opcode: zero result, err set.
        run_op(5'd0, 32'h3, 32'h4, lat);
        chk("ill_lat", 64'(lat), 64'd3);
        chk("ill_word", 64'(got[0]), 64'd0);
        chk("ill_err", 64'(err), 64'd1);
        chk("ill_zhi", 64'(z_hi), 64'd0);
        chk("ill_zlo", 64'(z_lo), 64'd0);
        run_op(5'd3, 32'h1, 32'h1, lat);
        chk("err_cleared", 64'(err), 64'd0);

        // Backpressure on DIV with ignored starts while busy.
        got.delete();
        @(negedge clk); #1;
        res_ready = 0; start = 1; op_in = 5'd16; opnd_a = 32'd100; opnd_b = 32'd7;
        @(negedge clk); #1;
        start = 0;
        wait_valid();
        repeat (5) begin
            @(negedge clk); #1;
            start = ~start; op_in = 5'd3; opnd_a = $urandom; opnd_b = $urandom;
        end
        res_ready = 1; start = 0;
        @(negedge clk); #1;
        res_ready = 0;
        chk("bp_hi_phase", 64'(res_is_hi), 64'd1);
        repeat (3) begin
            @(negedge clk); #1;
            start = ~start;
        end
        res_ready = 1; start = 0;
        wait_done("bp");
        chk("bp_nwords", 64'(got.size()), 64'd2);
        chk("bp_lo", 64'(got[0]), {31'd0, 1'b0, 32'd14});
        chk("bp_hi", 64'(got[1]), {31'd0, 1'b1, 32'd2});

        // Back-to-back: start held across done.
        got.delete();
        @(negedge clk); #1;
        start = 1; op_in = 5'd3; opnd_a = 32'd1; opnd_b = 32'd2;
        @(negedge clk); #1;
        op_in = 5'd4; opnd_a = 32'd10; opnd_b = 32'd20;
        wait_done("b2b_first");
        @(negedge clk); #1;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_alu_a", 64'(alu_a), 64'd10);
        start = 0;
        wait_done("b2b_second");
        chk("b2b_nwords", 64'(got.size()), 64'd2);
        chk("b2b_w0", 64'(got[0]), 64'd3);
        chk("b2b_w1", 64'(got[1]), 64'd30);

        // Asynchronous reset in the middle of a MUL's hi word.
        @(negedge clk); #1;
        res_ready = 0; start = 1; op_in = 5'd15; opnd_a = 32'd3; opnd_b = 32'd5;
        @(negedge clk); #1;
        start = 0;
        wait_valid();
        res_ready = 1;
        @(negedge clk); #1;
        res_ready = 0;
        chk("rst_in_hi", 64'(res_is_hi), 64'd1);
        #1 clr = 1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_is_hi", 64'(res_is_hi), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_z", {z_hi, z_lo}, 64'd0);
        chk("rst_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_op", 64'(alu_op), 64'd0);
        @(negedge clk); #1;
        clr = 0; res_ready = 1;
        run_op(5'd3, 32'h5, 32'h7, lat);
        chk("post_rst_lat", 64'(lat), 64'd3);
        chk("post_rst_word", 64'(got[0]), 64'h0000_000C);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            res_ready = ($urandom % 3) != 0;
            start = ($urandom % 4) == 0;
            op_in = (($urandom % 3) == 0) ? 5'($urandom) : legal_ops[$urandom % 12];
            opnd_a = $urandom;
            opnd_b = (($urandom % 8) == 0) ? 32'd0 : $urandom;
        end
        @(negedge clk); #1;
        start = 0; res_ready = 1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
